square_recon: RTL and testbench
===============================

Name: square_recon

Overview:
Inverse companion of the iterative integer square-root unit. Takes a root/remainder pair and reconstructs the radicand as data_out = root*root + remainder, using a sequential shift-add multiplier. Used as a checker or round-trip stage downstream of the square-root block, and as a standalone squarer (mode 1). One result per request, fixed latency, start/finish handshake.

Parameters:
ROOT_W, 8, width of the root operand; radicand/result width is 2*ROOT_W; remainder width is ROOT_W+1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
mode  input  3  operation select, sampled with start: 0 = root^2+remainder, 1 = root^2 only (remainder ignored), 2..7 reserved (treated as 0)
start  input  1  request strobe; accepted only in IDLE
sqr_root  input  ROOT_W  root operand, sampled with start
remainder  input  ROOT_W+1  remainder operand, sampled with start
data_out  output  2*ROOT_W  reconstructed radicand (low 2*ROOT_W bits of the sum)
overflow  output  1  sum exceeded 2*ROOT_W bits
rem_err  output  1  remainder > 2*root (pair not a legal sqrt result); feature-dependent
busy  output  1  high while the FSM is not IDLE
finish  output  1  one-cycle completion pulse; data_out/overflow/rem_err valid from this cycle

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; data_out=0, overflow=0, rem_err=0, busy=0, finish=0; internal accumulator, counter, and operand registers = 0.
- States: IDLE, MUL, ADD.
- IDLE: on start=1, capture sqr_root into multiplicand and multiplier registers, capture remainder (forced to 0 if mode==1), clear the 2*ROOT_W+1-bit accumulator, set cnt=0, go to MUL. busy goes high the next cycle.
- MUL: runs for ROOT_W cycles, LSB first. Each cycle: if multiplier[0]=1, accumulator += multiplicand<<cnt. Then shift the multiplier right by 1 and increment cnt. When cnt==ROOT_W-1, go to ADD.
- ADD: sum = accumulator + remainder, computed at 2*ROOT_W+1 bits. data_out <= sum[2*ROOT_W-1:0]; overflow <= sum[2*ROOT_W]; rem_err updated; finish <= 1; go to IDLE.
- Latency: start sampled at edge E0, finish high in the cycle following edge E0+ROOT_W+1 (9 cycles for ROOT_W=8). The latency is fixed and independent of operand values, including root=0.
- finish is high for exactly one cycle. data_out, overflow, and rem_err hold their values until the next ADD or until reset.
- start while busy=1 is ignored. It is not queued, and the captured operands are not disturbed.
- start in the cycle finish is high: the FSM is already IDLE, so the request is accepted and busy rises the next cycle.
- Operand inputs may change freely after the start cycle.
- Reset mid-operation aborts immediately. After release the FSM is IDLE with all outputs 0, and no finish pulse is generated for the aborted request.
- Width rule: the maximum legal pair (root=2^ROOT_W-1, rem=2*root) gives exactly 2^(2*ROOT_W)-1, so overflow=0. overflow=1 is possible only for illegal remainders.

Optional Feature:
SQR_RECON_CHECK_EN:
- Defined: in ADD, rem_err <= (mode!=1) && (captured remainder > 2*captured root). The comparison is done at ROOT_W+1 bits. The data_out computation is unchanged.
- Undefined: no comparator is built, and rem_err is tied to 0.
- The port exists in both builds.

Test Plan:
- Reset, then start with root=0, rem=0, mode=0 -> finish after 9 cycles; data_out=0, overflow=0, rem_err=0.
- root=12, rem=7, mode=0 -> data_out=151 (0x0097), overflow=0, rem_err=0; busy high for exactly 9 cycles.
- root=255, rem=510, mode=0 -> data_out=65535, overflow=0, rem_err=0. Then root=255, rem=511 -> data_out=0, overflow=1, rem_err=1 with SQR_RECON_CHECK_EN (0 without).
- root=200, rem=9, mode=1 -> data_out=40000 (remainder ignored), rem_err=0. Then root=3, rem=7, mode=0 -> data_out=16, rem_err=1 (check build).
- Start root=10, rem=5; pulse start with root=99 at cycle 3 -> ignored; single finish with data_out=105. Start issued in the finish cycle with root=2, rem=1 -> accepted; next finish gives data_out=5.
- Start root=50; assert rst_n=0 at cycle 4 -> all outputs 0 immediately, no finish. Release, then start root=7, rem=0 -> data_out=49 after 9 cycles.

Source files
------------

// File: rtl/square_recon.sv
// Radicand reconstruction: data_out = sqr_root^2 + remainder via an LSB-first shift-add multiplier.
// Define SQR_RECON_CHECK_EN to build the remainder legality comparator that drives rem_err.
module square_recon #(
   parameter int ROOT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            mode,
   input  logic                  start,
   input  logic [ROOT_W-1:0]     sqr_root,
   input  logic [ROOT_W:0]       remainder,
   output logic [2*ROOT_W-1:0]   data_out,
   output logic                  overflow,
   output logic                  rem_err,
   output logic                  busy,
   output logic                  finish
);

   localparam int ACC_W = 2*ROOT_W + 1;
   localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

   typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

   state_t              state;
   logic [ROOT_W-1:0]   mcand;
   logic [ROOT_W-1:0]   mplier;
   logic [ROOT_W:0]     rem_q;
   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    cnt;
   logic [ACC_W-1:0]    partial;
   logic [ACC_W-1:0]    sum;

   // One extra accumulator bit keeps the carry of the final add visible as overflow.
   assign partial = mplier[0] ? (ACC_W'(mcand) << cnt) : '0;
   assign sum     = acc + ACC_W'(rem_q);

`ifdef SQR_RECON_CHECK_EN
   logic sq_only;
`else
   assign rem_err = 1'b0;
`endif

   // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mcand    <= '0;
         mplier   <= '0;
         rem_q    <= '0;
         acc      <= '0;
         cnt      <= '0;
         data_out <= '0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         finish   <= 1'b0;
`ifdef SQR_RECON_CHECK_EN
         sq_only  <= 1'b0;
         rem_err  <= 1'b0;
`endif
      end else begin
         finish <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= sqr_root;
                  mplier <= sqr_root;
                  rem_q  <= (mode == 3'd1) ? '0 : remainder;
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= MUL;
`ifdef SQR_RECON_CHECK_EN
                  sq_only <= (mode == 3'd1);
`endif
               end
            end
            MUL: begin
               acc    <= acc + partial;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) state <= ADD;
            end
            ADD: begin
               data_out <= sum[2*ROOT_W-1:0];
               overflow <= sum[ACC_W-1];
`ifdef SQR_RECON_CHECK_EN
               rem_err  <= !sq_only && (rem_q > {mcand, 1'b0});
`endif
               finish   <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_square_recon.sv
// Self-checking bench for square_recon: a transaction-level model predicts every output each cycle,
// and directed vectors pin the model to hand-computed results.
module tb_square_recon;

   localparam int W = 8;
`ifdef SQR_RECON_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [2:0]       mode = '0;
   logic             start = 1'b0;
   logic [W-1:0]     sqr_root = '0;
   logic [W:0]       remainder = '0;
   logic [2*W-1:0]   data_out;
   logic             overflow;
   logic             rem_err;
   logic             busy;
   logic             finish;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   square_recon #(.ROOT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .start(start),
      .sqr_root(sqr_root), .remainder(remainder),
      .data_out(data_out), .overflow(overflow), .rem_err(rem_err),
      .busy(busy), .finish(finish)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: one request in flight, result due ROOT_W+1 edges after acceptance.
   bit              pending = 1'b0;
   bit              m_fin = 1'b0;
   bit              m_busy = 1'b0;
   int              cyc = 0;
   int              due = 0;
   logic [2*W-1:0]  q_data = '0, exp_data = '0;
   bit              q_ovf = 1'b0, exp_ovf = 1'b0;
   bit              q_err = 1'b0, exp_err = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending = 1'b0; m_fin = 1'b0; m_busy = 1'b0; cyc = 0;
         exp_data = '0; exp_ovf = 1'b0; exp_err = 1'b0;
      end else begin
         bit accept;
         int sq, addend;
         logic [2*W:0] total;
         cyc++;
         m_fin = 1'b0;
         accept = start && !pending;
         if (pending && cyc == due) begin
            exp_data = q_data; exp_ovf = q_ovf; exp_err = q_err;
            pending = 1'b0; m_fin = 1'b1;
         end
         if (accept) begin
            sq     = int'(sqr_root) * int'(sqr_root);
            addend = (mode == 3'd1) ? 0 : int'(remainder);
            total  = (2*W+1)'(sq + addend);
            q_data = total[2*W-1:0];
            q_ovf  = total[2*W];
            q_err  = CHK && (mode != 3'd1) && (int'(remainder) > 2 * int'(sqr_root));
            due    = cyc + W + 1;
            pending = 1'b1;
         end
         m_busy = pending;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, m_busy);
         check("finish", finish, m_fin);
         check("data_out", data_out, exp_data);
         check("overflow", overflow, exp_ovf);
         check("rem_err", rem_err, exp_err);
      end
   end

   task automatic wait_finish(output int bcnt);
      bit got = 1'b0;
      bcnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (finish) begin
            got = 1'b1;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
      if (!got) check("finish_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [W-1:0] r, input logic [W:0] rm, input logic [2:0] md,
                         output int bcnt);
      @(negedge clk);
      sqr_root = r; remainder = rm; mode = md; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sqr_root = W'($urandom); remainder = (W+1)'($urandom); mode = 3'($urandom);
      wait_finish(bcnt);
   endtask

   task automatic pin(input string name, input int d, input bit o, input bit e);
      check({name, "_dut_data"}, data_out, d);
      check({name, "_model_data"}, exp_data, d);
      check({name, "_dut_ovf"}, overflow, o);
      check({name, "_dut_err"}, rem_err, e);
      check({name, "_model_err"}, exp_err, e);
   endtask

   initial begin
      int bc;
      int fin_cnt;
      #1 rst_n = 1'b0;
      #3 chk_en = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      run_op(8'd0, 9'd0, 3'd0, bc);       pin("zero", 0, 1'b0, 1'b0);
      run_op(8'd12, 9'd7, 3'd0, bc);      pin("r12", 151, 1'b0, 1'b0);
      check("busy_cycles", bc, 9);
      run_op(8'd255, 9'd510, 3'd0, bc);   pin("max_legal", 65535, 1'b0, 1'b0);
      run_op(8'd255, 9'd511, 3'd0, bc);   pin("max_ovf", 0, 1'b1, CHK);
      run_op(8'd200, 9'd9, 3'd1, bc);     pin("square", 40000, 1'b0, 1'b0);
      run_op(8'd3, 9'd7, 3'd0, bc);       pin("bad_rem", 16, 1'b0, CHK);
      run_op(8'd6, 9'd20, 3'd5, bc);      pin("reserved", 56, 1'b0, CHK);

      // Start while busy is ignored; start in the finish cycle is accepted.
      @(negedge clk);
      sqr_root = 8'd10; remainder = 9'd5; mode = 3'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      sqr_root = 8'd99; remainder = 9'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_finish(bc);                    pin("ignore", 105, 1'b0, 1'b0);
      sqr_root = 8'd2; remainder = 9'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_finish(bc);                    pin("b2b", 5, 1'b0, 1'b0);

      // Reset mid-operation aborts with no finish pulse.
      @(negedge clk);
      sqr_root = 8'd50; remainder = 9'd0; mode = 3'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_data", data_out, 0);
      check("rst_busy", busy, 0);
      check("rst_finish", finish, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      fin_cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (finish) fin_cnt++;
      end
      check("no_finish_after_abort", fin_cnt, 0);
      run_op(8'd7, 9'd0, 3'd0, bc);       pin("post_rst", 49, 1'b0, 1'b0);
      check("post_rst_busy", bc, 9);

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
